// File: rtl/glb_stream_write_if.sv
// Ready/valid stream channel from the GLB transmitter into a fabric input IO.
// A word transfers on a posedge where valid && ready; while valid && !ready the master holds data and valid stable.
interface glb_stream_write_if;
  logic [16:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_stream_write.sv
// GLB stream transmitter: replays preloaded header/length/payload words onto a 17-bit ready/valid channel.
// Optional random bubble insertion is enabled by defining GLB_STREAM_WRITE_STALL_EN.
module glb_stream_write #(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned STALL_SH = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr_en,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [16:0]         cfg_wdata,
  input  logic [15:0]         cfg_tx_num,
  input  logic                seg_mode,
  input  logic                flush,
  glb_stream_write_if.master  stream,
  output logic                done,
  output logic                overrun,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HDR  = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] PTR_END    = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     STALL_MASK = 16'd3 << STALL_SH;

  logic [16:0]     mem [DEPTH];
  state_t          state;
  logic [ADDR_W:0] rd_ptr;
  logic [15:0]     tx_left;
  logic [1:0]      sub_left;
  logic [16:0]     len_left;
  logic            flush_q;
  logic [15:0]     gap_left;
  logic [15:0]     stall_delay;

  logic [16:0]     rd_word;
  logic            flush_rise;
  logic            flush_fall;
  logic            loading;
  logic            load_req;
  logic            gap_ok;
  logic            ptr_end;
  logic            load_go;

  always_ff @(posedge clk) begin
    if (cfg_wr_en) mem[cfg_addr] <= cfg_wdata;
  end

  assign rd_word    = mem[rd_ptr[ADDR_W-1:0]];
  assign flush_rise = flush & ~flush_q;
  assign flush_fall = flush_q & ~flush;
  assign loading    = (state == HDR) || (state == LEN) || (state == DATA);
  // The output register can take a new word when empty or when its word is being accepted.
  assign load_req   = loading && (!stream.valid || stream.ready);
  assign gap_ok     = (gap_left == 16'd0);
  assign ptr_end    = (rd_ptr == PTR_END);
  assign load_go    = load_req && gap_ok && !ptr_end;
  assign fsm_state  = state;

`ifdef GLB_STREAM_WRITE_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign stall_delay = lfsr & STALL_MASK;
`else
  assign stall_delay = 16'h0000 & STALL_MASK;
`endif

  // Bubble counter: holds valid low for stall_delay cycles before the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_left <= 16'd0;
    end else if (flush_rise) begin
      gap_left <= 16'd0;
    end else if ((state == ARM) || load_go) begin
      gap_left <= stall_delay;
    end else if (load_req && !gap_ok) begin
      gap_left <= gap_left - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stream.data  <= 17'd0;
      stream.valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      rd_ptr       <= '0;
      tx_left      <= 16'd0;
      sub_left     <= 2'd0;
      len_left     <= 17'd0;
      flush_q      <= 1'b0;
    end else begin
      flush_q <= flush;
      if (flush_rise) begin
        stream.valid <= 1'b0;
        rd_ptr       <= '0;
        done         <= 1'b0;
        overrun      <= 1'b0;
        state        <= IDLE;
      end else begin
        // A word accepted with nothing ready to replace it leaves the register empty.
        if (load_req && stream.valid && (!gap_ok || ptr_end)) stream.valid <= 1'b0;
        if (load_req && gap_ok && ptr_end) begin
          overrun <= 1'b1;
          state   <= DONE;
        end
        if (load_go) begin
          stream.data  <= rd_word;
          stream.valid <= 1'b1;
          rd_ptr       <= rd_ptr + (ADDR_W+1)'(1);
        end

        case (state)
          IDLE: begin
            if (flush_fall) state <= ARM;
          end
          ARM: begin
            tx_left <= cfg_tx_num;
            state   <= (cfg_tx_num == 16'd0) ? DONE : HDR;
          end
          HDR: begin
            if (load_go) begin
              sub_left <= seg_mode ? 2'd2 : 2'd1;
              state    <= LEN;
            end
          end
          LEN: begin
            if (load_go) begin
              len_left <= rd_word;
              // A zero length closes the whole transaction, even with a second substream pending.
              if (rd_word == 17'd0) begin
                tx_left <= tx_left - 16'd1;
                state   <= (tx_left == 16'd1) ? DONE : HDR;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (load_go) begin
              len_left <= len_left - 17'd1;
              if (len_left == 17'd1) begin
                sub_left <= sub_left - 2'd1;
                if (sub_left == 2'd2) begin
                  state <= LEN;
                end else begin
                  tx_left <= tx_left - 16'd1;
                  state   <= (tx_left == 16'd1) ? DONE : HDR;
                end
              end
            end
          end
          DONE: begin
            if (stream.valid && stream.ready) stream.valid <= 1'b0;
            if (!overrun && (!stream.valid || stream.ready)) done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glb_stream_write.sv
// Bench for glb_stream_write: directed cases plus random streams, scored against a memory-walking reference model.
module tb_glb_stream_write;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [16:0]       cfg_wdata = '0;
  logic [15:0]       cfg_tx_num = '0;
  logic              seg_mode = 1'b0;
  logic              flush = 1'b0;
  logic              done;
  logic              overrun;
  logic [2:0]        fsm_state;

  glb_stream_write_if sif ();

  glb_stream_write #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STALL_SH(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_tx_num (cfg_tx_num),
    .seg_mode   (seg_mode),
    .flush      (flush),
    .stream     (sif),
    .done       (done),
    .overrun    (overrun),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- ready driver ----------------
  // 0: always ready, 1: random, 2: toggle, 3: held low
  int ready_mode = 0;
  initial sif.ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sif.ready = 1'b1;
      1:       sif.ready = ($urandom_range(0, 3) != 0);
      2:       sif.ready = ~sif.ready;
      default: sif.ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [16:0] model_mem [DEPTH];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        hold_pend = 1'b0;
  logic [16:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_valid", 32'(sif.valid), 32'd1);
        check("hold_data", 32'(sif.data), 32'(hold_data));
      end
      hold_pend = sif.valid && !sif.ready && !flush;
      hold_data = sif.data;
      if (sif.valid && sif.ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got %0h expected no word", sif.data);
        end else begin
          check("stream_word", 32'(sif.data), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Walks the mirrored memory image following the stream format rules.
  task automatic build_expected(input int tx, input bit seg, output bit ovr);
    int ptr;
    ptr = 0;
    ovr = 1'b0;
    for (int t = 0; t < tx && !ovr; t++) begin
      int subs;
      subs = seg ? 2 : 1;
      if (ptr == DEPTH) begin ovr = 1'b1; break; end
      exp_q.push_back(model_mem[ptr]);
      ptr++;
      for (int s = 0; s < subs && !ovr; s++) begin
        int n;
        if (ptr == DEPTH) begin ovr = 1'b1; break; end
        n = int'(model_mem[ptr]);
        exp_q.push_back(model_mem[ptr]);
        ptr++;
        if (n == 0) break;
        for (int k = 0; k < n; k++) begin
          if (ptr == DEPTH) begin ovr = 1'b1; break; end
          exp_q.push_back(model_mem[ptr]);
          ptr++;
        end
      end
    end
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic write_word(input int addr, input logic [16:0] val);
    cfg_wr_en = 1'b1;
    cfg_addr  = ADDR_W'(addr);
    cfg_wdata = val;
    @(posedge clk) #1;
    cfg_wr_en = 1'b0;
    model_mem[addr] = val;
  endtask

  task automatic rand_word(input int addr);
    write_word(addr, 17'($urandom_range(0, 17'h1ffff)));
  endtask

  // Drops flush (arming), then checks latency, completion, flags and queue drain.
  task automatic complete_run(input int tx, input int mode, input bit ovr, input string tag);
    int nw;
    int cyc;
    nw = exp_q.size();
    flush = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check({tag, " pre_arm_quiet"}, 32'({sif.valid, done}), 32'd0);
      if (k == 4) begin
        if (tx != 0) check({tag, " first_valid"}, 32'(sif.valid), 32'd1);
        else         check({tag, " zero_tx_done"}, 32'(done), 32'd1);
      end
    end
    cyc = 0;
    while (!(done || overrun) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " finished_in_time"}, 32'(cyc < 3000), 32'd1);
    if (mode == 0 && !ovr && tx != 0) check({tag, " full_rate_cycles"}, 32'(cyc), 32'(nw));
    check({tag, " done"}, 32'(done), 32'(!ovr));
    check({tag, " overrun"}, 32'(overrun), 32'(ovr));
    check({tag, " all_words_seen"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " idle_after_end"}, 32'(sif.valid), 32'd0);
    @(posedge clk) #1;
  endtask

  task automatic run_stream(input int tx, input bit seg, input int mode, input string tag);
    bit ovr;
    exp_q.delete();
    build_expected(tx, seg, ovr);
    cfg_tx_num = 16'(tx);
    seg_mode   = seg;
    ready_mode = mode;
    flush = 1'b1;
    @(posedge clk) #1;
    complete_run(tx, mode, ovr, tag);
  endtask

  task automatic rand_stream(input int iter);
    int tx;
    bit seg;
    int ptr;
    tx  = $urandom_range(1, 3);
    seg = 1'($urandom_range(0, 1));
    ptr = 0;
    for (int t = 0; t < tx; t++) begin
      rand_word(ptr); ptr++;
      for (int s = 0; s < (seg ? 2 : 1); s++) begin
        int n;
        n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4);
        write_word(ptr, 17'(n)); ptr++;
        for (int k = 0; k < n; k++) begin rand_word(ptr); ptr++; end
        if (n == 0) break;
      end
    end
    run_stream(tx, seg, $urandom_range(0, 2), $sformatf("rand%0d", iter));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ovr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(sif.valid), 32'd0);
    check("reset_data", 32'(sif.data), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;
    for (int a = 0; a < DEPTH; a++) rand_word(a);

    // Single substream, full rate
    write_word(0, 17'h0); write_word(1, 17'd3);
    write_word(2, 17'h0000A); write_word(3, 17'h0000B); write_word(4, 17'h0000C);
    run_stream(1, 1'b0, 0, "seg0_basic");
    run_stream(1, 1'b0, 2, "seg0_toggle_ready");

    // Two substreams
    write_word(0, 17'h0); write_word(1, 17'd2); write_word(2, 17'h1); write_word(3, 17'h2);
    write_word(4, 17'd2); write_word(5, 17'h5); write_word(6, 17'h6);
    run_stream(1, 1'b1, 1, "seg1_two_subs");

    // Zero length ends the transaction despite seg_mode=1
    write_word(0, 17'h0); write_word(1, 17'd0);
    run_stream(1, 1'b1, 0, "seg1_zero_len");

    // Two transactions back to back
    write_word(0, 17'h0); write_word(1, 17'd1); write_word(2, 17'h1F00D);
    write_word(3, 17'h0); write_word(4, 17'd1); write_word(5, 17'h0BEEF);
    run_stream(2, 1'b0, 0, "two_tx");
    run_stream(0, 1'b0, 0, "zero_tx");

    // Flush in the middle of a payload while stalled, then restart from address 0
    rand_word(0); write_word(1, 17'd40);
    for (int a = 2; a < 42; a++) rand_word(a);
    exp_q.delete();
    build_expected(1, 1'b0, ovr);
    cfg_tx_num = 16'd1; seg_mode = 1'b0; ready_mode = 1;
    flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    begin
      int base;
      int cyc;
      base = n_acc;
      cyc = 0;
      while (n_acc < base + 5 && cyc < 200) begin @(posedge clk) #1; cyc++; end
      check("flush_reached_payload", 32'(cyc < 200), 32'd1);
    end
    ready_mode = 3;
    sif.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("flush_valid_before", 32'(sif.valid), 32'd1);
    flush = 1'b1;
    @(posedge clk) #1;
    check("flush_valid_dropped", 32'(sif.valid), 32'd0);
    exp_q.delete();
    build_expected(1, 1'b0, ovr);
    ready_mode = 1;
    complete_run(1, 1, ovr, "flush_rearm");

    // Length runs past the end of memory
    write_word(0, 17'h0); write_word(1, 17'd100);
    run_stream(1, 1'b0, 1, "overrun");
    // A fresh run after overrun clears the sticky flag
    write_word(0, 17'h0); write_word(1, 17'd1); write_word(2, 17'h12345);
    run_stream(1, 1'b0, 0, "after_overrun");

    // Asynchronous reset in the middle of a stream
    write_word(0, 17'h1); write_word(1, 17'd30);
    for (int a = 2; a < 32; a++) write_word(a, 17'(a + 100));
    exp_q.delete();
    build_expected(1, 1'b0, ovr);
    cfg_tx_num = 16'd1; ready_mode = 0;
    flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_valid", 32'(sif.valid), 32'd0);
    check("midrun_reset_data", 32'(sif.data), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk) #1;

    for (int i = 0; i < 20; i++) rand_stream(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
